// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core definitions for the pipeline sequencer and its neighbours.
// Holds the result-select encodings used by the ID/EX register, the
// sequencer FSM state type and the register-file address width.
package hazard_stall_ctrl_pkg;

  localparam int REGISTER_ADDR_WIDTH = 5;

  // Result-select encodings carried down the pipeline with each instruction.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of all non-clock signals between the datapath and the pipeline
// sequencer. Suffixes are relative to the sequencer: _i enters it, _o leaves.
//   slave  : sequencer side (hazard_stall_ctrl)
//   master : datapath / testbench side
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);
  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID_i;
  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID_i;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID_EX_i;
  logic [1:0]                     result_sel_ID_EX_i;
  logic                           reg_write_ID_EX_i;
  logic                           pc_src_EX_i;
  logic                           mem_access_EX_MEM_i;
  logic                           dmem_ready_i;
  logic                           dmem_req_o;
  logic                           stall_IF_o;
  logic                           stall_ID_o;
  logic                           flush_ID_o;
  logic                           stall_EX_o;
  logic                           flush_EX_o;
  logic                           stall_MEM_o;
  logic                           flush_WB_o;
  logic                           dmem_err_o;
  logic [CNT_WIDTH-1:0]           stall_cnt_o;
  logic [CNT_WIDTH-1:0]           flush_cnt_o;

  modport slave (
    input  rs1_ID_i, rs2_ID_i, rd_ID_EX_i, result_sel_ID_EX_i,
           reg_write_ID_EX_i, pc_src_EX_i, mem_access_EX_MEM_i, dmem_ready_i,
    output dmem_req_o, stall_IF_o, stall_ID_o, flush_ID_o, stall_EX_o,
           flush_EX_o, stall_MEM_o, flush_WB_o, dmem_err_o, stall_cnt_o,
           flush_cnt_o
  );

  modport master (
    output rs1_ID_i, rs2_ID_i, rd_ID_EX_i, result_sel_ID_EX_i,
           reg_write_ID_EX_i, pc_src_EX_i, mem_access_EX_MEM_i, dmem_ready_i,
    input  dmem_req_o, stall_IF_o, stall_ID_o, flush_ID_o, stall_EX_o,
           flush_EX_o, stall_MEM_o, flush_WB_o, dmem_err_o, stall_cnt_o,
           flush_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator, shared with the forwarding unit.
// Ports:
//   rs1_i, rs2_i  : source registers of the instruction in ID
//   rd_i          : destination of the instruction in EX
//   result_sel_i  : EX result select (RES_MEM marks a load)
//   reg_write_i   : EX instruction writes rd
//   load_use_o    : ID needs a value the EX load has not produced yet
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_i,
  input  logic [1:0]                     result_sel_i,
  input  logic                           reg_write_i,
  output logic                           load_use_o
);
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use_o = reg_write_i
                    & (result_sel_i == RES_MEM)
                    & (rd_i != {REGISTER_ADDR_WIDTH{1'b0}})
                    & ((rd_i == rs1_i) | (rd_i == rs2_i));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline sequencer: load-use and taken-branch hazards plus the
// data-memory wait-state handshake, driving hold/flush controls for every
// pipeline register.
// Ports:
//   cpu_clk, cpu_rst : core clock, synchronous active-high reset
//   bus (slave)      : hazard inputs, dmem handshake, stall/flush controls,
//                      sticky timeout error and performance counters
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 32
)(
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d, wait_inc_s;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_s, req_raw_s, mem_stall_s;
  logic stall_if_s, stall_id_s, flush_id_s, stall_ex_s, flush_ex_s;
  logic stall_mem_s, flush_wb_s;

  hazard_detect u_hazard_detect (
    .rs1_i        (bus.rs1_ID_i),
    .rs2_i        (bus.rs2_ID_i),
    .rd_i         (bus.rd_ID_EX_i),
    .result_sel_i (bus.result_sel_ID_EX_i),
    .reg_write_i  (bus.reg_write_ID_EX_i),
    .load_use_o   (load_use_s)
  );

  // ERROR stops issuing requests but keeps the pipeline frozen.
  assign req_raw_s   = bus.mem_access_EX_MEM_i & (state_q != ST_ERROR);
  assign mem_stall_s = (req_raw_s & ~bus.dmem_ready_i) | (state_q == ST_ERROR);

  // Output priority mux: memory stall, then taken branch, then load-use.
  always_comb begin
    stall_if_s  = 1'b0;
    stall_id_s  = 1'b0;
    flush_id_s  = 1'b0;
    stall_ex_s  = 1'b0;
    flush_ex_s  = 1'b0;
    stall_mem_s = 1'b0;
    flush_wb_s  = 1'b0;
    if (cpu_rst) begin
      stall_if_s = 1'b0;
    end else if (mem_stall_s) begin
      // Branch and load-use stay held in their stages until memory completes.
      stall_if_s  = 1'b1;
      stall_id_s  = 1'b1;
      stall_ex_s  = 1'b1;
      stall_mem_s = 1'b1;
      flush_wb_s  = 1'b1;
    end else if (bus.pc_src_EX_i) begin
      // The ID instruction is squashed, so any load-use it had is moot.
      flush_id_s = 1'b1;
      flush_ex_s = 1'b1;
    end else if (load_use_s) begin
      stall_if_s = 1'b1;
      stall_id_s = 1'b1;
      flush_ex_s = 1'b1;
    end else begin
      stall_if_s = 1'b0;
    end
  end

  // FSM next state; the wait counter holds stall cycles of the current access.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    wait_inc_s = wait_q + WAIT_W'(1);
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall_s) begin
          wait_d  = wait_inc_s;
          state_d = (wait_inc_s == WAIT_W'(WAIT_TIMEOUT)) ? ST_ERROR : ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          wait_d  = {WAIT_W{1'b0}};
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = {WAIT_W{1'b0}};
      end
    endcase
    err_d       = (state_d == ST_ERROR);
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_if_s);
    flush_cnt_d = flush_cnt_q + CNT_WIDTH'(flush_id_s);
  end

  // State, wait counter, error flag and performance counters.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_RUN;
      wait_q      <= {WAIT_W{1'b0}};
      err_q       <= 1'b0;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
      flush_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.dmem_req_o  = req_raw_s & ~cpu_rst;
  assign bus.stall_IF_o  = stall_if_s;
  assign bus.stall_ID_o  = stall_id_s;
  assign bus.flush_ID_o  = flush_id_s;
  assign bus.stall_EX_o  = stall_ex_s;
  assign bus.flush_EX_o  = flush_ex_s;
  assign bus.stall_MEM_o = stall_mem_s;
  assign bus.flush_WB_o  = flush_wb_s;
  assign bus.dmem_err_o  = err_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
endmodule
